// File: rtl/sm_diff_chain_if.sv
// Sample/result bundle for the sign-magnitude differentiator chain.
// The master drives samples and clear; the slave returns differences and status.
interface sm_diff_chain_if #(
    parameter int WIDTH = 16
);
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_mag;
    logic             in_sign;
    logic             out_valid;
    logic [WIDTH-1:0] out_mag;
    logic             out_sign;
    logic             out_primed;
    logic             ovf;

    modport master (
        output clear, in_valid, in_mag, in_sign,
        input  out_valid, out_mag, out_sign, out_primed, ovf
    );
    modport slave (
        input  clear, in_valid, in_mag, in_sign,
        output out_valid, out_mag, out_sign, out_primed, ovf
    );
endinterface

// File: rtl/sm_diff_chain.sv
// ORDER cascaded sign-magnitude delayed-subtraction stages, y[n] = x[n] - x[n-1],
// with valid pipeline, sync clear, saturate/wrap on overflow and a sticky overflow flag.
module sm_diff_chain #(
    parameter int WIDTH    = 16,
    parameter int ORDER    = 1,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               rst,
    sm_diff_chain_if.slave     bus
);
    localparam int CW = 3;

    // x_*[k] is the input of stage k: index 0 is the port, k>0 is stage k-1's output
    logic [ORDER-1:0][WIDTH-1:0] x_mag;
    logic [ORDER-1:0]            x_sign, x_vld, x_pt;

    logic [ORDER-1:0][WIDTH-1:0] h_mag_q, d_mag_q, r_mag;
    logic [ORDER-1:0]            h_sign_q, d_sign_q, d_vld_q, d_pt_q;
    logic [ORDER-1:0]            r_sign, r_ovf;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          primed_q, primed_d;
    logic          ovf_q, ovf_d;

    // Input -0 folds to +0 so history never holds a negative zero
    assign x_mag[0]  = bus.in_mag;
    assign x_sign[0] = bus.in_sign & (|bus.in_mag);
    assign x_vld[0]  = bus.in_valid;
    assign x_pt[0]   = (cnt_q >= CW'(ORDER - 1));

    for (genvar k = 0; k < ORDER; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign x_mag[k]  = d_mag_q[k-1];
            assign x_sign[k] = d_sign_q[k-1];
            assign x_vld[k]  = d_vld_q[k-1];
            assign x_pt[k]   = d_pt_q[k-1];
        end

        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] mag_w;
        logic             sign_w, ovf_w;

        always_comb begin
            sum    = {1'b0, x_mag[k]} + {1'b0, h_mag_q[k]};
            ovf_w  = 1'b0;
            sign_w = x_sign[k];
            mag_w  = '0;
            if (x_sign[k] == h_sign_q[k]) begin
                if (x_mag[k] >= h_mag_q[k]) begin
                    mag_w = x_mag[k] - h_mag_q[k];
                end else begin
                    mag_w  = h_mag_q[k] - x_mag[k];
                    sign_w = ~x_sign[k];
                end
            end else begin
                ovf_w = sum[WIDTH];
                mag_w = (sum[WIDTH] && SATURATE != 0) ? '1 : sum[WIDTH-1:0];
            end
            if (mag_w == '0) sign_w = 1'b0;
        end

        assign r_mag[k]  = mag_w;
        assign r_sign[k] = sign_w;
        assign r_ovf[k]  = ovf_w & x_vld[k];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.in_valid && cnt_q != CW'(ORDER)) cnt_d = cnt_q + 1'b1;
        ovf_d    = ovf_q | (|r_ovf);
        primed_d = primed_q | (d_vld_q[ORDER-1] & d_pt_q[ORDER-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_mag_q  <= '0;
            h_sign_q <= '0;
            d_mag_q  <= '0;
            d_sign_q <= '0;
            d_vld_q  <= '0;
            d_pt_q   <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (bus.clear) begin
            h_mag_q  <= '0;
            h_sign_q <= '0;
            d_mag_q  <= '0;
            d_sign_q <= '0;
            d_vld_q  <= '0;
            d_pt_q   <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            ovf_q    <= ovf_d;
            d_vld_q  <= x_vld;
            for (int k = 0; k < ORDER; k++) begin
                // Bubbles leave history and data untouched
                if (x_vld[k]) begin
                    h_mag_q[k]  <= x_mag[k];
                    h_sign_q[k] <= x_sign[k];
                    d_mag_q[k]  <= r_mag[k];
                    d_sign_q[k] <= r_sign[k];
                    d_pt_q[k]   <= x_pt[k];
                end
            end
        end
    end

    // primed shows up together with the first fully-primed output and then sticks
    assign bus.out_valid  = d_vld_q[ORDER-1];
    assign bus.out_mag    = d_mag_q[ORDER-1];
    assign bus.out_sign   = d_sign_q[ORDER-1];
    assign bus.out_primed = primed_q | (d_vld_q[ORDER-1] & d_pt_q[ORDER-1]);
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_sm_diff_chain.sv
// Bench for sm_diff_chain: three instances (ORDER1/sat, ORDER2/sat, ORDER1/wrap) share one
// stimulus stream and are checked against an integer-arithmetic reference model.
module tb_sm_diff_chain;
    localparam int W    = 16;
    localparam int MAXM = 65535;

    logic clk, rst;
    logic clear, in_valid, in_sign;
    logic [W-1:0] in_mag;

    sm_diff_chain_if #(.WIDTH(W)) ifa ();
    sm_diff_chain_if #(.WIDTH(W)) ifb ();
    sm_diff_chain_if #(.WIDTH(W)) ifc ();

    assign ifa.clear = clear; assign ifa.in_valid = in_valid; assign ifa.in_mag = in_mag; assign ifa.in_sign = in_sign;
    assign ifb.clear = clear; assign ifb.in_valid = in_valid; assign ifb.in_mag = in_mag; assign ifb.in_sign = in_sign;
    assign ifc.clear = clear; assign ifc.in_valid = in_valid; assign ifc.in_mag = in_mag; assign ifc.in_sign = in_sign;

    sm_diff_chain #(.WIDTH(W), .ORDER(1), .SATURATE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    sm_diff_chain #(.WIDTH(W), .ORDER(2), .SATURATE(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    sm_diff_chain #(.WIDTH(W), .ORDER(1), .SATURATE(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    logic ov[3], os[3], op[3], oo[3];
    logic [W-1:0] om[3];
    assign ov[0] = ifa.out_valid; assign om[0] = ifa.out_mag; assign os[0] = ifa.out_sign;
    assign op[0] = ifa.out_primed; assign oo[0] = ifa.ovf;
    assign ov[1] = ifb.out_valid; assign om[1] = ifb.out_mag; assign os[1] = ifb.out_sign;
    assign op[1] = ifb.out_primed; assign oo[1] = ifb.ovf;
    assign ov[2] = ifc.out_valid; assign om[2] = ifc.out_mag; assign os[2] = ifc.out_sign;
    assign op[2] = ifc.out_primed; assign oo[2] = ifc.ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {int val; bit primed; bit ovf; int due;} exp_t;
    exp_t q[3][$];
    int   hist[3][4];
    int   cnt[3];
    bit   movf[3], eprim[3], eovf[3];
    int   tests, fails, cyc;

    function automatic int ord(int d); return (d == 1) ? 2 : 1; endfunction
    function automatic bit sat(int d); return (d == 2) ? 1'b0 : 1'b1; endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 4; k++) hist[d][k] = 0;
            cnt[d] = 0; movf[d] = 0; eprim[d] = 0; eovf[d] = 0;
            q[d].delete();
        end
    endtask

    // Each stage is plain integer subtraction, then clamped/wrapped to WIDTH magnitude bits
    task automatic model_accept(int x);
        for (int d = 0; d < 3; d++) begin
            int v, nv, m;
            exp_t e;
            v = x;
            for (int k = 0; k < ord(d); k++) begin
                nv = v - hist[d][k];
                m  = (nv < 0) ? -nv : nv;
                if (m > MAXM) begin
                    movf[d] = 1;
                    m = sat(d) ? MAXM : (m & MAXM);
                end
                hist[d][k] = v;
                v = (nv < 0) ? -m : m;
            end
            if (cnt[d] < ord(d)) cnt[d]++;
            e.val = v; e.primed = (cnt[d] >= ord(d)); e.ovf = movf[d]; e.due = cyc + ord(d) - 1;
            q[d].push_back(e);
        end
    endtask

    task automatic check_cycle();
        for (int d = 0; d < 3; d++) begin
            bit   ev;
            exp_t e;
            ev = (q[d].size() > 0) && (q[d][0].due == cyc);
            chk($sformatf("d%0d out_valid", d), 32'(ov[d]), 32'(ev));
            if (ev) begin
                e = q[d].pop_front();
                chk($sformatf("d%0d out_mag", d), 32'(om[d]), 32'((e.val < 0) ? -e.val : e.val));
                chk($sformatf("d%0d out_sign", d), 32'(os[d]), 32'(e.val < 0));
                if (e.primed) eprim[d] = 1;
                eovf[d] = e.ovf;
            end
            chk($sformatf("d%0d out_primed", d), 32'(op[d]), 32'(eprim[d]));
            if (d != 1) chk($sformatf("d%0d ovf", d), 32'(oo[d]), 32'(eovf[d]));
        end
    endtask

    task automatic check_zero(string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s d%0d out_valid", tag, d), 32'(ov[d]), 32'd0);
            chk($sformatf("%s d%0d out_mag", tag, d), 32'(om[d]), 32'd0);
            chk($sformatf("%s d%0d out_sign", tag, d), 32'(os[d]), 32'd0);
            chk($sformatf("%s d%0d out_primed", tag, d), 32'(op[d]), 32'd0);
            chk($sformatf("%s d%0d ovf", tag, d), 32'(oo[d]), 32'd0);
        end
    endtask

    task automatic step(bit v, bit s, int m, bit c);
        in_valid = v; in_sign = s; in_mag = W'(m); clear = c;
        @(posedge clk);
        cyc++;
        if (c) model_clear();
        else if (v) model_accept(s ? -m : m);
        #1 check_cycle();
        @(negedge clk);
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1 check_zero("async_rst");
        model_clear();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_mag = '0;
        model_clear();
        #2 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // basic sequence +100,+40,-30
        step(1, 0, 100, 0); step(1, 0, 40, 0); step(1, 1, 30, 0); idle(3);

        // ramp back-to-back
        step(0, 0, 0, 1);
        step(1, 0, 0, 0); step(1, 0, 10, 0); step(1, 0, 20, 0); step(1, 0, 30, 0); idle(3);

        // full-scale opposite signs: saturate vs wrap, ovf sticky
        step(0, 0, 0, 1);
        step(1, 0, 65535, 0); step(1, 1, 65535, 0); idle(4);
        chk("d1 ovf sticky", 32'(oo[1]), 32'(movf[1]));

        // negative zero and equal-value zero normalisation
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); step(1, 0, 5, 0); step(1, 0, 7, 0); step(1, 0, 7, 0); idle(3);

        // ramp with random input gaps
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 10 * i, 0);
            idle($urandom_range(1, 3));
        end
        idle(3);

        // async reset mid-stream, then clear colliding with a sample
        step(1, 0, 30, 0); step(1, 0, 70, 0);
        do_reset();
        step(1, 0, 50, 0); idle(3);
        step(1, 0, 20, 0); step(1, 0, 99, 1);
        check_zero("clear");
        step(1, 0, 50, 0); idle(3);

        // randomized stream with occasional clears
        step(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            int m;
            case ($urandom_range(0, 3))
                0:       m = MAXM;
                1:       m = 0;
                default: m = $urandom_range(0, MAXM);
            endcase
            step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), m, $urandom_range(0, 99) < 3);
        end
        idle(4);
        chk("d1 ovf final", 32'(oo[1]), 32'(movf[1]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
